// File: rtl/desequenciador_pkg.sv
// Shared definitions for the desequenciador serial frame receiver:
// frame geometry, field positions inside the data shift register and the FSM states.
package desequenciador_pkg;

  localparam int FRAME_BITS = 12;
  localparam int DATA_BITS  = 11;

  // Data shift register holds line bits 2..12; the first data bit ends up in the MSB.
  localparam int C_MSB     = 10;
  localparam int C_LSB     = 7;
  localparam int B_MSB     = 6;
  localparam int B_LSB     = 3;
  localparam int BP_POS    = 2;
  localparam int STOP1_POS = 1;
  localparam int STOP2_POS = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_TAIL  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] c;
    logic [3:0] b;
    logic       bp;
    logic       cod;
  } frame_t;

  // The duplicated stop field carries ~COD twice; both copies must agree.
  function automatic logic stop_ok(input logic [DATA_BITS-1:0] data);
    return data[STOP1_POS] == data[STOP2_POS];
  endfunction

  function automatic frame_t decode(input logic [DATA_BITS-1:0] data);
    frame_t f;
    f.c   = data[C_MSB:C_LSB];
    f.b   = data[B_MSB:B_LSB];
    f.bp  = data[BP_POS];
    f.cod = ~data[STOP1_POS];
    return f;
  endfunction

endpackage

// File: rtl/desequenciador_sincronizador.sv
// Two-flop synchroniser for the serial line when the source is not clk-synchronous.
// Used by desequenciador only when DESEQ_SYNC_EN is defined.
module desequenciador_sincronizador (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage resynchronisation chain, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/desequenciador.sv
// Serial frame receiver: start detection, mid-bit sampling of 11 bits, stop-field check
// and parallel presentation with VAL/ERR strobes. DESEQ_SYNC_EN adds a two-flop input synchroniser.
module desequenciador
  import desequenciador_pkg::*;
#(
  parameter int OVS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SI,
  input  logic       HAB,
  output logic [3:0] C,
  output logic [3:0] B,
  output logic       BP,
  output logic       COD,
  output logic       VAL,
  output logic       ERR
);

  localparam int MID      = (OVS - 1) / 2;
  localparam int TAIL_LEN = OVS - 1 - MID;

  localparam logic [3:0] OVS_M1   = 4'(OVS - 1);
  localparam logic [3:0] MID_M1   = 4'(MID - 1);
  localparam logic [3:0] TAIL_M1  = 4'(TAIL_LEN - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic                 si_s;
  state_t               state_r;
  logic [3:0]           cnt_r;
  logic [3:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] frame_s;
  logic                 tick_s;
  frame_t               dec_s;

`ifdef DESEQ_SYNC_EN
  desequenciador_sincronizador u_sincronizador (
    .clk (clk),
    .rst (rst),
    .d   (SI),
    .q   (si_s)
  );
`else
  assign si_s = SI;
`endif

  // Next shift-register image including the bit being sampled now, and the bit-period tick.
  always_comb begin
    frame_s = {shift_r[DATA_BITS-2:0], si_s};
    dec_s   = decode(frame_s);
    if (cnt_r == OVS_M1) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Receive FSM with registered frame outputs and single-cycle strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      bit_cnt_r <= 4'd0;
      shift_r   <= '0;
      C         <= 4'd0;
      B         <= 4'd0;
      BP        <= 1'b0;
      COD       <= 1'b0;
      VAL       <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      VAL <= 1'b0;
      ERR <= 1'b0;
      if (!HAB) begin
        state_r   <= ST_IDLE;
        cnt_r     <= 4'd0;
        bit_cnt_r <= 4'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (si_s) begin
              cnt_r     <= 4'd0;
              bit_cnt_r <= 4'd0;
              shift_r   <= '0;
              // With no half-bit delay the detecting sample already confirms the start bit.
              state_r   <= (MID == 0) ? ST_DATA : ST_START;
            end
          end

          ST_START: begin
            if (cnt_r == MID_M1) begin
              cnt_r   <= 4'd0;
              state_r <= si_s ? ST_DATA : ST_IDLE;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end

          ST_DATA: begin
            if (tick_s) begin
              cnt_r     <= 4'd0;
              shift_r   <= frame_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == LAST_BIT) begin
                bit_cnt_r <= 4'd0;
                if (stop_ok(frame_s)) begin
                  C   <= dec_s.c;
                  B   <= dec_s.b;
                  BP  <= dec_s.bp;
                  COD <= dec_s.cod;
                  VAL <= 1'b1;
                end else begin
                  ERR <= 1'b1;
                end
                state_r <= (TAIL_LEN == 0) ? ST_IDLE : ST_TAIL;
              end
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end

          ST_TAIL: begin
            // Run out the remainder of the last bit so the next start edge is seen cleanly.
            if (cnt_r == TAIL_M1) begin
              cnt_r   <= 4'd0;
              state_r <= ST_IDLE;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end

          default: begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            bit_cnt_r <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_desequenciador.sv
// Self-checking bench: an OVS=1 and an OVS=4 receiver driven with table vectors,
// hand-written corner sequences and random frames, checked every cycle against an event scoreboard.
module tb_desequenciador;
  import desequenciador_pkg::*;

`ifdef DESEQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_a, rst_b, si_a, si_b, hab_a, hab_b;
  logic [3:0] c_a, b_a, c_b, b_b;
  logic       bp_a, cod_a, val_a, err_a, bp_b, cod_b, val_b, err_b;

  always #5 clk = ~clk;

  desequenciador #(.OVS(1)) u_a (
    .clk(clk), .rst(rst_a), .SI(si_a), .HAB(hab_a),
    .C(c_a), .B(b_a), .BP(bp_a), .COD(cod_a), .VAL(val_a), .ERR(err_a)
  );

  desequenciador #(.OVS(4)) u_b (
    .clk(clk), .rst(rst_b), .SI(si_b), .HAB(hab_b),
    .C(c_b), .B(b_b), .BP(bp_b), .COD(cod_b), .VAL(val_b), .ERR(err_b)
  );

  typedef struct {
    int         inst;
    int         edge_no;
    bit         err;
    logic [3:0] c;
    logic [3:0] b;
    logic       bp;
    logic       cod;
  } ev_t;

  typedef struct {
    logic [3:0] c;
    logic [3:0] b;
    logic       bp;
    logic       cod;
  } out_t;

  typedef struct {
    int          inst;
    logic [11:0] line;
    logic [3:0]  c;
    logic [3:0]  b;
    logic        bp;
    logic        cod;
    bit          err;
    int          gap;
  } vec_t;

  ev_t  evq[$];
  out_t mdl[2];
  vec_t tbl[6];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int ovs_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Compare one receiver against the scoreboard after the current edge.
  task automatic check_inst(input int i);
    logic [3:0] ac, ab;
    logic       abp, acod, aval, aerr;
    bit         exp_val = 1'b0;
    bit         exp_err = 1'b0;
    int         hit = -1;
    string      tag = (i == 0) ? "ovs1" : "ovs4";
    if (i == 0) begin
      ac = c_a; ab = b_a; abp = bp_a; acod = cod_a; aval = val_a; aerr = err_a;
    end else begin
      ac = c_b; ab = b_b; abp = bp_b; acod = cod_b; aval = val_b; aerr = err_b;
    end
    foreach (evq[j]) if (evq[j].inst == i && evq[j].edge_no == cyc) hit = j;
    if (hit >= 0) begin
      exp_err = evq[hit].err;
      exp_val = !exp_err;
      if (!exp_err) begin
        mdl[i].c   = evq[hit].c;
        mdl[i].b   = evq[hit].b;
        mdl[i].bp  = evq[hit].bp;
        mdl[i].cod = evq[hit].cod;
      end
      evq.delete(hit);
    end
    chk({tag, ".VAL"}, 32'(aval), 32'(exp_val));
    chk({tag, ".ERR"}, 32'(aerr), 32'(exp_err));
    chk({tag, ".C"},   32'(ac),   32'(mdl[i].c));
    chk({tag, ".B"},   32'(ab),   32'(mdl[i].b));
    chk({tag, ".BP"},  32'(abp),  32'(mdl[i].bp));
    chk({tag, ".COD"}, 32'(acod), 32'(mdl[i].cod));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      check_inst(0);
      check_inst(1);
    end
  end

  task automatic set_si(input int i, input logic v);
    if (i == 0) si_a = v; else si_b = v;
  endtask

  task automatic idle(input int i, input int n);
    set_si(i, 1'b0);
    repeat (n) @(negedge clk);
  endtask

  task automatic drop_events(input int i);
    for (int j = evq.size() - 1; j >= 0; j--) if (evq[j].inst == i) evq.delete(j);
  endtask

  // Drive the first nbits line bits of a frame (start first) and schedule its expected strobe.
  task automatic send(input int i, input logic [11:0] line, input logic [3:0] ec, input logic [3:0] eb,
                      input logic ebp, input logic ecod, input bit eerr, input int nbits);
    ev_t e;
    int  ovs = ovs_of(i);
    e.inst    = i;
    e.edge_no = cyc + 1 + (ovs - 1) / 2 + 11 * ovs + LAT;
    e.err     = eerr;
    e.c = ec; e.b = eb; e.bp = ebp; e.cod = ecod;
    evq.push_back(e);
    for (int k = 11; k > 11 - nbits; k--) begin
      set_si(i, line[k]);
      repeat (ovs) @(negedge clk);
    end
  endtask

  // Random frame built from fields; the line image follows from the frame format.
  task automatic send_random(input int i);
    logic [3:0]  rc = 4'($urandom_range(15, 0));
    logic [3:0]  rb = 4'($urandom_range(15, 0));
    logic        rbp = 1'($urandom_range(1, 0));
    logic        rcod = 1'($urandom_range(1, 0));
    bit          bad = ($urandom_range(9, 0) == 0);
    logic [11:0] line = {1'b1, rc, rb, rbp, ~rcod, bad ? rcod : ~rcod};
    send(i, line, rc, rb, rbp, rcod, bad, 12);
    idle(i, $urandom_range(2, 0));
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; si_a = 1'b0; si_b = 1'b0; hab_a = 1'b1; hab_b = 1'b1;
    for (int i = 0; i < 2; i++) mdl[i] = '{4'd0, 4'd0, 1'b0, 1'b0};

    tbl[0] = '{0, 12'b1_1010_0011_1_11, 4'hA, 4'h3, 1'b1, 1'b0, 1'b0, 2};
    tbl[1] = '{0, 12'b1_0101_1100_0_10, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2};
    tbl[2] = '{0, 12'b1_1111_0000_0_00, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 0};
    tbl[3] = '{0, 12'b1_0000_1111_1_11, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 3};
    tbl[4] = '{0, 12'b1_0110_1001_0_01, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 3};
    tbl[5] = '{1, 12'b1_1001_0110_1_00, 4'h9, 4'h6, 1'b1, 1'b1, 1'b0, 3};

    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      send(tbl[t].inst, tbl[t].line, tbl[t].c, tbl[t].b, tbl[t].bp, tbl[t].cod, tbl[t].err, 12);
      idle(tbl[t].inst, tbl[t].gap);
    end
    idle(0, 4);

    // Single-cycle glitch in IDLE at four cycles per bit, then a real frame.
    set_si(1, 1'b1);
    @(negedge clk);
    idle(1, 3);
    send(1, 12'b1_1010_0011_1_11, 4'hA, 4'h3, 1'b1, 1'b0, 1'b0, 12);
    idle(1, 3);

    // Reset during bit 6 clears everything; the next frame must still decode.
    send(0, 12'b1_1100_0101_0_00, 4'hC, 4'h5, 1'b0, 1'b1, 1'b0, 7);
    rst_a = 1'b1; si_a = 1'b0;
    drop_events(0);
    mdl[0] = '{4'd0, 4'd0, 1'b0, 1'b0};
    @(negedge clk);
    rst_a = 1'b0;
    idle(0, 3);
    send(0, 12'b1_0111_1000_1_00, 4'h7, 4'h8, 1'b1, 1'b1, 1'b0, 12);
    idle(0, 3);

    // Dropping the enable mid-frame discards it but keeps the last good outputs.
    send(1, 12'b1_0011_0011_0_11, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 7);
    hab_b = 1'b0; si_b = 1'b0;
    drop_events(1);
    repeat (4) @(negedge clk);
    hab_b = 1'b1;
    idle(1, 2);
    send(1, 12'b1_1110_0001_0_11, 4'hE, 4'h1, 1'b0, 1'b0, 1'b0, 12);
    idle(1, 3);

    for (int r = 0; r < 25; r++) send_random(0);
    idle(0, 3);
    for (int r = 0; r < 20; r++) send_random(1);
    idle(1, 3);

    repeat (LAT + 60) @(negedge clk);
    chk("pending_strobes", 32'(evq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
